// File: rtl/func_32b_accum_stage.sv
// Downstream stage of the 32-bit add/sub unit: registered pass-through or group accumulation,
// fed into a 2-entry output skid buffer. Optional macro ACCUM_SAT_EN selects saturating sums plus sat_flag.
module func_32b_accum_stage #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic             CGRA_Clock,
  input  logic             CGRA_Reset,
  input  logic [size-1:0]  in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [CNT_W-1:0] acc_len,
  output logic [size-1:0]  out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef ACCUM_SAT_EN
  ,
  output logic             sat_flag
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef ACCUM_SAT_EN
  // Signed saturating add; bit [size] flags that clamping occurred.
  function automatic logic [size:0] add_f(input logic [size-1:0] a, input logic [size-1:0] b);
    logic [size-1:0] s;
    logic            ovf;
    s   = a + b;
    ovf = (a[size-1] == b[size-1]) && (s[size-1] != a[size-1]);
    if (ovf) begin
      s = a[size-1] ? {1'b1, {(size-1){1'b0}}} : {1'b0, {(size-1){1'b1}}};
    end else begin
      s = s;
    end
    return {ovf, s};
  endfunction
`else
  function automatic logic [size-1:0] add_f(input logic [size-1:0] a, input logic [size-1:0] b);
    return a + b;
  endfunction
`endif

  state_e           state_q, state_d;
  logic [size-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic [1:0]       occ_q, occ_d;
  logic [size-1:0]  head_data_q, head_data_d;
  logic             head_last_q, head_last_d;
  logic [size-1:0]  skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic [size-1:0]  push_data_s;
  logic             push_last_s;
  logic [size-1:0]  sum_s;
  logic [CNT_W-1:0] len_in_s;
  logic [CNT_W-1:0] cnt_inc_s;

`ifdef ACCUM_SAT_EN
  logic             grp_sat_q, grp_sat_d;
  logic             head_sat_q, head_sat_d;
  logic             skid_sat_q, skid_sat_d;
  logic             push_sat_s;
  logic             ovf_s;
  assign {ovf_s, sum_s} = add_f(acc_q, in);
`else
  assign sum_s = add_f(acc_q, in);
`endif

  assign accept_s  = in_valid & in_ready_q;
  assign pop_s     = out_valid_q & out_ready;
  assign len_in_s  = (acc_len == {CNT_W{1'b0}}) ? CNT_ONE : acc_len;
  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Group sequencing: decides what (if anything) an accepted beat pushes.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    push_s      = 1'b0;
    push_data_s = in;
    push_last_s = 1'b1;
`ifdef ACCUM_SAT_EN
    grp_sat_d   = grp_sat_q;
    push_sat_s  = 1'b0;
`endif
    if (accept_s) begin
      case (state_q)
        IDLE: begin
          if (!mode || (len_in_s == CNT_ONE)) begin
            push_s = 1'b1;
          end else begin
            acc_d   = in;
            cnt_d   = CNT_ONE;
            len_d   = len_in_s;
            state_d = ACCUM;
`ifdef ACCUM_SAT_EN
            grp_sat_d = 1'b0;
`endif
          end
        end
        ACCUM: begin
          if (cnt_inc_s == len_q) begin
            push_s      = 1'b1;
            push_data_s = sum_s;
            acc_d       = {size{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            state_d     = IDLE;
`ifdef ACCUM_SAT_EN
            push_sat_s  = grp_sat_q | ovf_s;
            grp_sat_d   = 1'b0;
`endif
          end else begin
            acc_d = sum_s;
            cnt_d = cnt_inc_s;
`ifdef ACCUM_SAT_EN
            grp_sat_d = grp_sat_q | ovf_s;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = {size{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Skid buffer: a push never arrives while full because in_ready tracks occupancy.
  always_comb begin
    occ_d       = occ_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
`ifdef ACCUM_SAT_EN
    head_sat_d  = head_sat_q;
    skid_sat_d  = skid_sat_q;
`endif
    case (occ_q)
      2'd0: begin
        if (push_s) begin
          head_data_d = push_data_s;
          head_last_d = push_last_s;
`ifdef ACCUM_SAT_EN
          head_sat_d  = push_sat_s;
`endif
          occ_d       = 2'd1;
        end else begin
          occ_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_data_d = push_data_s;
          head_last_d = push_last_s;
`ifdef ACCUM_SAT_EN
          head_sat_d  = push_sat_s;
`endif
        end else if (push_s) begin
          skid_data_d = push_data_s;
          skid_last_d = push_last_s;
`ifdef ACCUM_SAT_EN
          skid_sat_d  = push_sat_s;
`endif
          occ_d       = 2'd2;
        end else if (pop_s) begin
          occ_d = 2'd0;
        end else begin
          occ_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_data_d = skid_data_q;
          head_last_d = skid_last_q;
`ifdef ACCUM_SAT_EN
          head_sat_d  = skid_sat_q;
`endif
          occ_d       = 2'd1;
        end else begin
          occ_d = 2'd2;
        end
      end
      default: occ_d = 2'd0;
    endcase
    out_valid_d = (occ_d != 2'd0);
    in_ready_d  = (occ_d != 2'd2);
  end

  // State and buffer registers.
  always_ff @(posedge CGRA_Clock or negedge CGRA_Reset) begin
    if (!CGRA_Reset) begin
      state_q     <= IDLE;
      acc_q       <= {size{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      len_q       <= {CNT_W{1'b0}};
      occ_q       <= 2'd0;
      head_data_q <= {size{1'b0}};
      head_last_q <= 1'b0;
      skid_data_q <= {size{1'b0}};
      skid_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef ACCUM_SAT_EN
      grp_sat_q   <= 1'b0;
      head_sat_q  <= 1'b0;
      skid_sat_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef ACCUM_SAT_EN
      grp_sat_q   <= grp_sat_d;
      head_sat_q  <= head_sat_d;
      skid_sat_q  <= skid_sat_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out       = head_data_q;
  assign out_last  = head_last_q;
  assign out_valid = out_valid_q;
`ifdef ACCUM_SAT_EN
  assign sat_flag  = head_sat_q;
`endif

endmodule

// File: doc/func_32b_accum_stage.md
Name: func_32b_accum_stage

Overview:
- Downstream stage of the 32-bit add/sub functional unit. Consumes its result word through a valid/ready handshake.
- Two modes: registered pass-through, or accumulation of a group of acc_len results into one sum (reduction for the sum microbenchmark).
- Output is driven from a 2-entry skid buffer, so back-pressure never drops data.

Parameters:
size, 32, datapath width of in, out and the accumulator.
CNT_W, 8, width of acc_len and of the internal beat counter.

Ports:
CGRA_Clock  input  1  clock; all state updates on the rising edge.
CGRA_Reset  input  1  asynchronous, active-low reset (0 = reset).
in  input  size  result word from the add/sub unit.
in_valid  input  1  in holds a valid word.
in_ready  output  1  stage can accept a word this cycle.
mode  input  1  0 = pass-through, 1 = accumulate.
acc_len  input  CNT_W  beats per accumulation group; 0 is treated as 1.
out  output  size  buffered result.
out_valid  output  1  out holds a valid word.
out_ready  input  1  consumer accepts out this cycle.
out_last  output  1  out is the final sum of a group; always 1 in pass-through mode.

Behaviour:
- Reset (async assert, sync release):
  - out = 0, out_valid = 0, out_last = 0, in_ready = 1.
  - Buffer empty, accumulator = 0, beat counter = 0, FSM in IDLE.
- Handshakes:
  - Input beat accepted when in_valid & in_ready.
  - Output beat retired when out_valid & out_ready.
  - in_ready is a registered function of buffer occupancy: 1 iff occupancy < 2 after the current edge. It has no combinational path from out_ready.
- Output buffer:
  - 2-entry FIFO (head register drives out, plus one skid register).
  - Push and pop in the same cycle leave occupancy unchanged.
  - Order is preserved. out/out_last stay stable while out_valid & !out_ready.
- Pass-through (mode = 0):
  - Each accepted word is pushed with last = 1.
  - Latency: word accepted at edge N appears with out_valid = 1 after edge N.
  - Throughput: 1 word/cycle while out_ready = 1.
- Accumulate FSM, states IDLE, ACCUM:
  - IDLE, beat accepted:
    - Latch mode and acc_len; let L = max(acc_len, 1).
    - If L = 1: push in with last = 1 and stay in IDLE.
    - Otherwise: acc = in, cnt = 1, go to ACCUM.
  - ACCUM, beat accepted:
    - sum = acc + in, modulo 2^size (wraps; no carry out).
    - If cnt + 1 = L: push sum with last = 1, clear acc and cnt, go to IDLE.
    - Otherwise: acc = sum, cnt = cnt + 1.
  - Changes to mode or acc_len while in ACCUM are ignored until the group completes.
  - mode is sampled only in IDLE.
  - Non-final beats push nothing but still require in_ready = 1. This is the uniform rule, and it keeps the final beat from being blocked.
- Boundary cases:
  - Buffer full: in_ready = 0 and no state changes. An in_valid held high waits.
  - Final beat and pop in the same cycle: both take effect.
  - Reset mid-group discards the partial sum and the buffer contents.

Optional Feature:
- Macro ACCUM_SAT_EN.
- Defined:
  - Accumulation is two's-complement signed saturating. On positive overflow the result is 2^(size-1)-1; on negative overflow it is -2^(size-1).
  - Adds output port sat_flag (1 bit). It travels through the buffer alongside the data and is 1 when any addition in that group saturated.
  - In pass-through mode sat_flag = 0.
- Not defined:
  - Wrap-around arithmetic as specified above.
  - No sat_flag port.

Test Plan:
- Reset then idle: CGRA_Reset = 0 for 3 cycles, release -> out = 0, out_valid = 0, in_ready = 1.
- Pass-through streaming: mode = 0, in = 5, 6, 7 on consecutive cycles, out_ready = 1 -> out = 5, 6, 7 one cycle after each accept, out_last = 1 on each.
- Back-pressure: mode = 0, out_ready = 0, in_valid held with in = 1, 2, 3 -> in_ready falls after 2 accepts and 3 is held off. Raise out_ready -> out = 1, 2, 3 in order, nothing lost.
- Accumulate: mode = 1, acc_len = 4, in = 10, 20, 30, 40 -> single output 100 with out_last = 1. acc_len = 0 with in = 9 -> output 9.
- Wrap (macro undefined): acc_len = 2, in = 32'hFFFFFFFF, 32'h00000002 -> out = 32'h00000001.
- Saturate (ACCUM_SAT_EN defined): acc_len = 2, in = 32'h7FFFFFFF, 32'h00000001 -> out = 32'h7FFFFFFF, sat_flag = 1.
- Reset mid-group: acc_len = 4, two beats accepted, assert reset -> no output. After release, new group 1, 1, 1, 1 -> out = 4.
